// File: rtl/jtframe_pll_phase.sv
// jtframe_pll_phase
// Walks the dynamic phase of individual PLL output channels one step at a
// time until each reaches a requested signed position. One position
// register per channel records the steps applied since the PLL last locked.
// Every step is a two-cycle phase_en pulse, followed by a phase_done
// handshake: wait for it to rise, then wait for it to fall again.
// Each handshake phase is bounded by a timeout of TO clock cycles.

module jtframe_pll_phase #(
  parameter int NCH = 6,
  parameter int CW  = 5,
  parameter int PW  = 8,
  parameter int TO  = 255,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 locked,
  input  logic                 req,
  input  logic [CHW-1:0]       req_ch,
  input  logic signed [PW-1:0] req_pos,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic signed [PW-1:0] pos,
  output logic                 phase_en,
  output logic                 updn,
  output logic [CW-1:0]        cntsel,
  input  logic                 phase_done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_STEP  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  // The timer only counts cycles spent in WAIT or GAP without the
  // awaited phase_done level. It expires on the TO-th such cycle.
  localparam int            TW       = (TO > 0) ? $clog2(TO + 1) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TO - 1);
  localparam logic [CHW:0]  NCH_LIM  = (CHW + 1)'(NCH);

  logic [2:0]           state;
  logic [CHW-1:0]       ch_q;
  logic signed [PW-1:0] tgt_q;
  logic signed [PW-1:0] pos_r [NCH];
  logic                 locked_q;
  logic [TW-1:0]        tmr;
  logic                 step_cnt;
  logic                 phase_en_q;

  logic                 lock_fall;
  logic                 ch_ok;
  logic signed [PW-1:0] cur_pos;
  logic signed [PW-1:0] step_val;
  logic                 in_hs;
  logic                 hs_hit;
  logic                 tmr_expired;
  logic                 step_ack;

  // Remember last cycle's lock status so a loss of lock can be seen as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked;
    end
  end

  // Select the latched channel's position and derive the handshake conditions
  always_comb begin
    cur_pos = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == CHW'(i)) begin
        cur_pos = pos_r[i];
      end
    end
    lock_fall   = locked_q & ~locked;
    ch_ok       = ({1'b0, ch_q} < NCH_LIM);
    step_val    = updn ? PW'(1) : '1;
    in_hs       = (state == ST_WAIT) || (state == ST_GAP);
    hs_hit      = ((state == ST_WAIT) &&  phase_done) ||
                  ((state == ST_GAP)  && !phase_done);
    tmr_expired = in_hs && !hs_hit && (tmr == TMR_LAST);
    step_ack    = (state == ST_WAIT) && phase_done && !lock_fall;
  end

  // The position shown is always that of the most recently latched channel
  assign pos = cur_pos;

  // A loss of lock blanks phase_en at once, without waiting for a clock edge
  assign phase_en = phase_en_q & locked;

  // Handshake timeout counter; restarts whenever a handshake phase begins or completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (lock_fall || !in_hs || hs_hit || tmr_expired) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  // Per-channel positions: wiped on loss of lock, moved one step per acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        pos_r[i] <= '0;
      end
    end else if (lock_fall) begin
      for (int i = 0; i < NCH; i++) begin
        pos_r[i] <= '0;
      end
    end else if (step_ack) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_q == CHW'(i)) begin
          pos_r[i] <= pos_r[i] + step_val;
        end
      end
    end
  end

  // Request sequencer: validate, then step and handshake until on target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ch_q       <= '0;
      tgt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      updn       <= 1'b0;
      cntsel     <= '0;
      step_cnt   <= 1'b0;
      phase_en_q <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (lock_fall) begin
        phase_en_q <= 1'b0;
        step_cnt   <= 1'b0;
        if (state != ST_IDLE) begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (req) begin
              ch_q  <= req_ch;
              tgt_q <= req_pos;
              busy  <= 1'b1;
              state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (!ch_ok || !locked) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else if (tgt_q == cur_pos) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              updn       <= (tgt_q > cur_pos);
              cntsel     <= CW'(ch_q);
              phase_en_q <= 1'b1;
              step_cnt   <= 1'b0;
              state      <= ST_STEP;
            end
          end
          ST_STEP: begin
            if (step_cnt) begin
              phase_en_q <= 1'b0;
              step_cnt   <= 1'b0;
              state      <= ST_WAIT;
            end else begin
              step_cnt <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (phase_done) begin
              state <= ST_GAP;
            end else if (tmr_expired) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          ST_GAP: begin
            if (!phase_done) begin
              if (cur_pos == tgt_q) begin
                state <= ST_FIN;
              end else begin
                phase_en_q <= 1'b1;
                step_cnt   <= 1'b0;
                state      <= ST_STEP;
              end
            end else if (tmr_expired) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          ST_FIN: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            busy       <= 1'b0;
            phase_en_q <= 1'b0;
            state      <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/jtframe_pll_phase.md
JTFRAME_PLL_PHASE -- requirements
Module: jtframe_pll_phase

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NCH, 6, PLL output channels under control (1..18).
- CW, 5, width of the PLL phase counter-select bus.
- PW, 8, signed width of the phase position (in PLL phase steps).
- TO, 255, timeout in clk cycles waiting for phase_done.
- CHW, $clog2(NCH) (min 1), width of the channel index.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1, single clock; all logic runs on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- locked, in, 1, PLL lock status.
- req, in, 1, one-cycle request strobe.
- req_ch, in, CHW, target channel.
- req_pos, in, PW, signed absolute target position.
- busy, out, 1, a request is in progress.
- done, out, 1, one-cycle success pulse.
- err, out, 1, one-cycle failure pulse.
- pos, out, PW, current position of the last addressed channel.
- phase_en, out, 1, PLL phase-step enable.
- updn, out, 1, step direction: 1 = positive, 0 = negative.
- cntsel, out, CW, PLL counter select.
- phase_done, in, 1, PLL step acknowledge, active high.

Function
REQ-003 The block SHALL hold one signed PW-bit position register per channel, representing steps applied since the last lock.
REQ-004 The FSM SHALL have the states IDLE, CHECK, STEP, WAIT, GAP and FIN.
REQ-005 In IDLE with req=1, the block SHALL latch req_ch/req_pos, set busy=1 on the next cycle and enter CHECK.
REQ-006 If req_ch>=NCH or locked=0 at CHECK, the block SHALL pulse err for 1 cycle, return to IDLE and leave all positions unchanged.
REQ-007 If the target equals the current position at CHECK, the block SHALL pulse done 1 cycle later and return to IDLE without asserting phase_en.
REQ-008 Otherwise CHECK SHALL set updn=(target>current) and cntsel=zero-extended channel index, then enter STEP.
REQ-009 STEP SHALL hold phase_en=1 for exactly 2 clk cycles, then enter WAIT with phase_en=0.
REQ-010 WAIT SHALL wait for phase_done=1, then move the channel position by +1 or -1 per updn and enter GAP.
REQ-011 GAP SHALL wait for phase_done=0; then, if the position equals the target, it SHALL enter FIN, otherwise STEP.
REQ-012 FIN SHALL pulse done for 1 cycle, clear busy and return to IDLE.
REQ-013 If WAIT or GAP exceeds TO cycles, the block SHALL pulse err, clear busy and return to IDLE; the position SHALL reflect only acknowledged steps.
REQ-014 A req while busy=1 SHALL be ignored, with no done and no err.
REQ-015 Position arithmetic SHALL be PW-bit signed; the FSM never steps past the target, so no wrap occurs; req_pos takes any PW-bit value.
REQ-016 A locked 1->0 transition SHALL clear all positions to 0 in the same cycle and force phase_en=0. If busy, the FSM SHALL also go to IDLE and pulse err.
REQ-017 The pos output SHALL show the position of the latched channel and update in the cycle after each step is acknowledged.
REQ-018 done and err SHALL never be asserted in the same cycle.
REQ-019 cntsel and updn SHALL stay stable from CHECK through FIN.

Reset
REQ-020 With rst_n=0, the block SHALL be asynchronously in IDLE with busy=0, done=0, err=0, phase_en=0, updn=0, cntsel=0, pos=0, all positions=0 and the timeout counter=0.
REQ-021 On rst_n release, operation SHALL start on the first rising clk edge; the block SHALL NOT produce a done or err pulse because of reset.

Verification
REQ-022 Step test: locked=1, req ch=1 pos=+3, PLL model acks 4 cycles after phase_en. Required: 3 phase_en pulses of 2 cycles each, updn=1, cntsel=1, pos 1,2,3, then done.
REQ-023 Return test: from +3, req pos=-2 on ch=1. Required: 5 steps with updn=0, final pos=-2, done, no err.
REQ-024 Null and bad requests: req with target equal to current gives done and no phase_en; req_ch=6 with NCH=6 gives err; req with locked=0 gives err; all positions unchanged.
REQ-025 Timeout: PLL model never acks, TO=255. Required: err exactly 257 cycles after phase_en rises, position unchanged, busy=0.
REQ-026 Lock loss and reset: drop locked mid-sequence on ch=5. Required: err pulse, phase_en=0, every channel position=0. Separately, rst_n=0 during STEP gives all outputs at reset values immediately.
